// File: rtl/ixc_cap_loop_pkg.sv
// rtl/ixc_cap_loop_pkg.sv - shared state and halt-cause encodings for the capture-loop controller
package ixc_cap_loop_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_STALL = 2'd3
  } capState_t;

  typedef enum logic [1:0] {
    CAUSE_RESET = 2'd0,
    CAUSE_STOP  = 2'd1,
    CAUSE_STEP  = 2'd2,
    CAUSE_WAIT  = 2'd3
  } haltCause_t;

endpackage

// File: rtl/ixc_cap_loop_div.sv
// rtl/ixc_cap_loop_div.sv - behavioural-clock divider and bClkEn/bcLatchEn pulse pair
module ixc_cap_loop_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic gate,
  output logic fire,
  output logic bClkEn,
  output logic bcLatchEn
);
  localparam int DIV_W = $clog2(DIV);

  logic [DIV_W-1:0] divCnt;
  logic             wrap;

  assign wrap = (divCnt == DIV_W'(DIV - 1));
  // fire is the decision; bClkEn is its registered image one cycle later
  assign fire = run && wrap && gate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divCnt    <= '0;
      bClkEn    <= 1'b0;
      bcLatchEn <= 1'b0;
    end else begin
      bClkEn    <= fire;
      bcLatchEn <= bClkEn;
      if (clear) begin
        divCnt <= '0;
      end else if (run) begin
        divCnt <= wrap ? '0 : divCnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/ixc_cap_loop_ctrl.sv
// rtl/ixc_cap_loop_ctrl.sv - capture-loop controller: behavioural clock, latch enable, halt and cycle count
module ixc_cap_loop_ctrl
  import ixc_cap_loop_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int DIV    = 2,
  parameter int DRAIN  = 2,
  parameter int RESUME = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             stop,
  input  logic             freeRun,
  input  logic [CNT_W-1:0] stepN,
  input  logic             bpWait,
  output logic             bClkEn,
  output logic             bcLatchEn,
  output logic             bpHalt,
  output logic             busy,
  output logic [CNT_W-1:0] cycCnt,
  output logic [1:0]       haltCause
);
  localparam int DRAIN_W = $clog2(DRAIN + 1);
  localparam int LOW_W   = $clog2(RESUME + 2);

  capState_t          state;
  capState_t          nextState;
  haltCause_t         cause;
  haltCause_t         nextCause;
  logic               bpWaitQ;
  logic               stepMode;
  logic               fire;
  logic               divClear;
  logic               divRun;
  logic               divGate;
  logic               accept;
  logic               lastStep;
  logic               drainDone;
  logic               resumeOk;
  logic [CNT_W-1:0]   stepRem;
  logic [DRAIN_W-1:0] drainCnt;
  logic [LOW_W-1:0]   lowCnt;

  assign accept    = (state == ST_HALT) && go && !stop && (freeRun || (stepN != '0));
  assign lastStep  = fire && stepMode && (stepRem == CNT_W'(1));
  assign drainDone = (drainCnt == DRAIN_W'(DRAIN - 1));
  assign resumeOk  = (lowCnt == LOW_W'(RESUME));
  assign divClear  = (nextState == ST_RUN) && (state != ST_RUN);
  assign divRun    = (state == ST_RUN);
  assign divGate   = !bpWaitQ && !stop;
  assign haltCause = cause;

  ixc_cap_loop_div #(
    .DIV(DIV)
  ) uDiv (
    .clk      (clk),
    .rst      (rst),
    .clear    (divClear),
    .run      (divRun),
    .gate     (divGate),
    .fire     (fire),
    .bClkEn   (bClkEn),
    .bcLatchEn(bcLatchEn)
  );

  always_comb begin
    nextState = state;
    nextCause = cause;
    case (state)
      ST_HALT: begin
        if (accept) nextState = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          nextState = ST_DRAIN;
          nextCause = CAUSE_STOP;
        end else if (bpWaitQ) begin
          nextState = ST_DRAIN;
          nextCause = CAUSE_WAIT;
        end else if (lastStep) begin
          nextState = ST_DRAIN;
          nextCause = CAUSE_STEP;
        end
      end
      ST_DRAIN: begin
        if (drainDone) nextState = (cause == CAUSE_WAIT) ? ST_STALL : ST_HALT;
      end
      ST_STALL: begin
        if (stop) begin
          nextState = ST_HALT;
          nextCause = CAUSE_STOP;
        end else if (resumeOk) begin
          nextState = ST_RUN;
        end
      end
      default: nextState = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_HALT;
      cause    <= CAUSE_RESET;
      bpWaitQ  <= 1'b0;
      bpHalt   <= 1'b1;
      busy     <= 1'b0;
      cycCnt   <= '0;
      stepRem  <= '0;
      stepMode <= 1'b0;
      drainCnt <= '0;
      lowCnt   <= '0;
    end else begin
      state   <= nextState;
      cause   <= nextCause;
      bpWaitQ <= bpWait;
      // status flags follow the state being entered so they stay registered
      bpHalt  <= (nextState == ST_HALT) || (nextState == ST_STALL);
      busy    <= (nextState == ST_RUN) || (nextState == ST_DRAIN);
      if (fire) cycCnt <= cycCnt + CNT_W'(1);
      if (accept) begin
        stepRem  <= stepN;
        stepMode <= !freeRun;
      end else if (fire && stepMode) begin
        stepRem <= stepRem - CNT_W'(1);
      end
      drainCnt <= (state == ST_DRAIN) ? drainCnt + DRAIN_W'(1) : '0;
      // any high wait sample restarts the resume qualification
      if ((state != ST_STALL) || bpWaitQ) begin
        lowCnt <= '0;
      end else if (!resumeOk) begin
        lowCnt <= lowCnt + LOW_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ixc_cap_loop_ctrl.sv
// tb/tb_ixc_cap_loop_ctrl.sv - directed self-checking bench for ixc_cap_loop_ctrl
module tb_ixc_cap_loop_ctrl;
  localparam int CNT_W = 4;
  localparam int DIV   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             go;
  logic             stop;
  logic             freeRun;
  logic [CNT_W-1:0] stepN;
  logic             bpWait;
  logic             bClkEn;
  logic             bcLatchEn;
  logic             bpHalt;
  logic             busy;
  logic [CNT_W-1:0] cycCnt;
  logic [1:0]       haltCause;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulseCnt = 0;
  int latchCnt = 0;
  int latchErr = 0;
  int firstCyc = -1;
  int lastCyc = -1;
  logic prevEn = 1'b0;

  ixc_cap_loop_ctrl #(
    .CNT_W (CNT_W),
    .DIV   (DIV),
    .DRAIN (2),
    .RESUME(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .stop     (stop),
    .freeRun  (freeRun),
    .stepN    (stepN),
    .bpWait   (bpWait),
    .bClkEn   (bClkEn),
    .bcLatchEn(bcLatchEn),
    .bpHalt   (bpHalt),
    .busy     (busy),
    .cycCnt   (cycCnt),
    .haltCause(haltCause)
  );

  always #5 clk = ~clk;

  // pulse monitor: cyc is the index of the most recent rising edge
  always @(posedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      prevEn = 1'b0;
    end else begin
      if (bcLatchEn !== prevEn) latchErr++;
      if (bClkEn === 1'b1) begin
        pulseCnt++;
        if (firstCyc < 0) firstCyc = cyc;
        lastCyc = cyc;
      end
      if (bcLatchEn === 1'b1) latchCnt++;
      prevEn = bClkEn;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitIdle(output bit ok);
    int n = 0;
    while (!(busy === 1'b0 && bpHalt === 1'b1) && n < 80) begin
      @(negedge clk);
      n++;
    end
    ok = (busy === 1'b0 && bpHalt === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; stop = 1'b0; freeRun = 1'b0; stepN = '0; bpWait = 1'b0;
    tick(3);
    tests++; if ({bClkEn, bcLatchEn, bpHalt, busy} !== 4'b0010) begin fails++; $display("FAIL reset_flags: got %b want 0010", {bClkEn, bcLatchEn, bpHalt, busy}); end
    tests++; if (cycCnt !== 4'd0) begin fails++; $display("FAIL reset_cyccnt: got %0d want 0", cycCnt); end
    tests++; if (haltCause !== 2'd0) begin fails++; $display("FAIL reset_cause: got %0d want 0", haltCause); end
    rst = 1'b0;
    tick(2);
    tests++; if ({bClkEn, bpHalt, busy} !== 3'b010) begin fails++; $display("FAIL reset_idle: got %b want 010", {bClkEn, bpHalt, busy}); end
  endtask

  task automatic test_step();
    int p0, l0, c0;
    bit ok;
    p0 = pulseCnt; l0 = latchCnt; firstCyc = -1;
    freeRun = 1'b0; stepN = 4'd5; go = 1'b1; c0 = cyc;
    tick(1); go = 1'b0;
    waitIdle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL step_done: busy=%b bpHalt=%b want 0/1 (timeout)", busy, bpHalt); end
    tests++; if (pulseCnt - p0 !== 5) begin fails++; $display("FAIL step_pulses: got %0d want 5", pulseCnt - p0); end
    tests++; if (latchCnt - l0 !== 5) begin fails++; $display("FAIL step_latches: got %0d want 5", latchCnt - l0); end
    tests++; if (firstCyc - c0 !== DIV + 1) begin fails++; $display("FAIL step_first_latency: got %0d want %0d", firstCyc - c0, DIV + 1); end
    tests++; if (lastCyc - firstCyc !== 4 * DIV) begin fails++; $display("FAIL step_spacing: got %0d want %0d", lastCyc - firstCyc, 4 * DIV); end
    tests++; if (cycCnt !== 4'd5) begin fails++; $display("FAIL step_cyccnt: got %0d want 5", cycCnt); end
    tests++; if (haltCause !== 2'd2) begin fails++; $display("FAIL step_cause: got %0d want 2", haltCause); end
  endtask

  task automatic test_wait_stall();
    int c, d, p2, n;
    freeRun = 1'b1; go = 1'b1;
    tick(1); go = 1'b0;
    tick(6);
    c = cyc; bpWait = 1'b1;
    tick(2); p2 = pulseCnt;
    tick(7);
    tests++; if ({bpHalt, busy} !== 2'b10) begin fails++; $display("FAIL wait_stalled: got %b want 10", {bpHalt, busy}); end
    tests++; if (haltCause !== 2'd3) begin fails++; $display("FAIL wait_cause: got %0d want 3", haltCause); end
    tick(1); d = cyc; bpWait = 1'b0; firstCyc = -1;
    tick(3);
    tests++; if (bpHalt !== 1'b1) begin fails++; $display("FAIL wait_early_resume: bpHalt=%b want 1 at fall+3", bpHalt); end
    tick(1);
    tests++; if ({bpHalt, busy} !== 2'b01) begin fails++; $display("FAIL wait_resume: got %b want 01 at fall+4", {bpHalt, busy}); end
    tests++; if (pulseCnt !== p2) begin fails++; $display("FAIL wait_no_pulse: got %0d pulses want %0d", pulseCnt, p2); end
    n = 0;
    while (firstCyc < 0 && n < 10) begin tick(1); n++; end
    tests++; if (firstCyc - d !== 6) begin fails++; $display("FAIL wait_resume_phase: first pulse at fall+%0d want fall+6 (c=%0d)", firstCyc - d, c); end
  endtask

  task automatic test_stop_run();
    bit ok;
    int p0;
    stop = 1'b1;
    waitIdle(ok);
    p0 = pulseCnt;
    tests++; if (!ok) begin fails++; $display("FAIL stoprun_halt: busy=%b bpHalt=%b want 0/1", busy, bpHalt); end
    tests++; if (haltCause !== 2'd1) begin fails++; $display("FAIL stoprun_cause: got %0d want 1", haltCause); end
    tick(3);
    tests++; if (pulseCnt !== p0) begin fails++; $display("FAIL stoprun_quiet: got %0d pulses want %0d", pulseCnt, p0); end
    stop = 1'b0;
    tick(1);
  endtask

  task automatic test_step_glitch();
    int p0, c, d, n;
    bit ok;
    p0 = pulseCnt;
    freeRun = 1'b0; stepN = 4'd3; go = 1'b1;
    tick(1); go = 1'b0;
    n = 0;
    while (pulseCnt == p0 && n < 10) begin tick(1); n++; end
    tests++; if (pulseCnt - p0 !== 1) begin fails++; $display("FAIL glitch_first_pulse: got %0d want 1", pulseCnt - p0); end
    c = cyc; bpWait = 1'b1;
    tick(6); bpWait = 1'b0;
    tick(1); bpWait = 1'b1;
    tick(3);
    tests++; if (bpHalt !== 1'b1) begin fails++; $display("FAIL glitch_hold: bpHalt=%b want 1 at c+%0d", bpHalt, cyc - c); end
    d = cyc; bpWait = 1'b0;
    tick(3);
    tests++; if (bpHalt !== 1'b1) begin fails++; $display("FAIL glitch_restart: bpHalt=%b want 1 at fall+3 (d=%0d)", bpHalt, d); end
    tick(1);
    tests++; if (bpHalt !== 1'b0) begin fails++; $display("FAIL glitch_resume: bpHalt=%b want 0 at fall+4", bpHalt); end
    waitIdle(ok);
    tests++; if (pulseCnt - p0 !== 3) begin fails++; $display("FAIL glitch_total: got %0d pulses want 3", pulseCnt - p0); end
    tests++; if (haltCause !== 2'd2) begin fails++; $display("FAIL glitch_cause: got %0d want 2", haltCause); end
  endtask

  task automatic test_stop_stall();
    int p0;
    freeRun = 1'b1; go = 1'b1;
    tick(1); go = 1'b0;
    tick(4); bpWait = 1'b1;
    tick(8);
    tests++; if ({bpHalt, haltCause} !== 3'b111) begin fails++; $display("FAIL stall_entry: got bpHalt/cause %b want 111", {bpHalt, haltCause}); end
    stop = 1'b1;
    tick(1);
    tests++; if ({bpHalt, busy, haltCause} !== 4'b1001) begin fails++; $display("FAIL stall_stop: got %b want 1001", {bpHalt, busy, haltCause}); end
    bpWait = 1'b0; p0 = pulseCnt;
    go = 1'b1;
    tick(1); go = 1'b0;
    tick(5);
    tests++; if ({bpHalt, busy} !== 2'b10 || pulseCnt !== p0) begin fails++; $display("FAIL go_with_stop: bpHalt/busy %b pulses %0d want 10 and %0d", {bpHalt, busy}, pulseCnt, p0); end
    stop = 1'b0;
    tick(1);
  endtask

  task automatic test_wrap();
    int p0, n;
    bit ok;
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    p0 = pulseCnt;
    freeRun = 1'b1; go = 1'b1;
    tick(1); go = 1'b0;
    n = 0;
    while (pulseCnt - p0 < 20 && n < 100) begin tick(1); n++; end
    stop = 1'b1;
    waitIdle(ok);
    stop = 1'b0;
    tests++; if (pulseCnt - p0 !== 20) begin fails++; $display("FAIL wrap_pulses: got %0d want 20", pulseCnt - p0); end
    tests++; if (cycCnt !== 4'd4) begin fails++; $display("FAIL wrap_cyccnt: got %0d want 4", cycCnt); end
  endtask

  task automatic test_async_reset();
    int n, l0;
    freeRun = 1'b1; go = 1'b1;
    tick(1); go = 1'b0;
    n = 0;
    while (bClkEn !== 1'b1 && n < 10) begin tick(1); n++; end
    tests++; if (bClkEn !== 1'b1) begin fails++; $display("FAIL arst_pre: bClkEn=%b want 1 (timeout)", bClkEn); end
    l0 = latchCnt;
    #1 rst = 1'b1;
    #1;
    tests++; if ({bClkEn, bcLatchEn, bpHalt, busy} !== 4'b0010) begin fails++; $display("FAIL arst_flags: got %b want 0010", {bClkEn, bcLatchEn, bpHalt, busy}); end
    tests++; if ({cycCnt, haltCause} !== 6'd0) begin fails++; $display("FAIL arst_counts: cycCnt %0d cause %0d want 0 0", cycCnt, haltCause); end
    @(negedge clk);
    tests++; if (bcLatchEn !== 1'b0 || latchCnt !== l0) begin fails++; $display("FAIL arst_no_latch: bcLatchEn=%b latches %0d want 0 and %0d", bcLatchEn, latchCnt, l0); end
    rst = 1'b0;
    tick(3);
    tests++; if ({bClkEn, bpHalt, busy} !== 3'b010) begin fails++; $display("FAIL arst_after: got %b want 010", {bClkEn, bpHalt, busy}); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_step();
    test_wait_stall();
    test_stop_run();
    test_step_glitch();
    test_stop_stall();
    test_wrap();
    test_async_reset();
    tests++; if (latchErr !== 0) begin fails++; $display("FAIL latch_follows_clken: %0d misaligned cycles want 0", latchErr); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
